jrb_serial_mem_bridge: RTL and testbench

//  Parametrised serial master linking the jrb core to external ROM/RAM over a 4-wire link: sclk, serial_out, serial_in, ready.

---
 rtl/jrb_serial_mem_bridge.sv | 192 +++++++++++++++++++
 tb/tb_jrb_serial_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jrb_serial_mem_bridge.sv
// ============================================================================
// jrb_serial_mem_bridge : bit-serial ROM/RAM master with wait-states/timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module jrb_serial_mem_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 1,
  parameter int TIMEOUT = 0,
  // derived from NUM_CH; leave at default
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic              serial_out_o,
  input  logic              serial_in_i,
  input  logic              ready_i
);

  localparam int N       = 1 + CH_W + ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(N);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BIT_W-1:0]   DATA_BIT  = BIT_W'(DATA_W);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam logic [CH_W:0]      NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOW    = 2'd1,
    S_HIGH   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        frame_q, frame_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                read_q, read_d;
  logic                sout_q, sout_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ch_bad;

  assign ch_bad = ({1'b0, ch_i} >= NUM_CH_L);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    div_d   = div_q;
    stall_d = stall_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    read_d  = read_q;
    sout_d  = sout_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          frame_d = {we_i, ch_i, addr_i, wdata_i};
          read_d  = ~we_i;
          bit_d   = BIT_W'(N - 1);
          div_d   = '0;
          stall_d = '0;
          rx_d    = '0;
          if (ch_bad) begin
            state_d = S_FINISH;
            err_d   = 1'b1;
          end else begin
            state_d = S_LOW;
            sout_d  = we_i;
          end
        end
      end
      S_LOW: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else if (ready_i) begin
          state_d = S_HIGH;
          div_d   = '0;
          stall_d = '0;
        end else if (TIMEOUT > 0) begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_d == STALL_MAX) begin
            state_d = S_FINISH;
            err_d   = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (div_q == '0 && read_q && bit_q < DATA_BIT)
          rx_d = DATA_W'({rx_q, serial_in_i});
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (bit_q == '0) begin
            state_d = S_FINISH;
          end else begin
            // next bit goes out on the same edge that drops sclk
            state_d = S_LOW;
            bit_d   = bit_q - BIT_W'(1);
            frame_d = frame_q << 1;
            sout_d  = (read_q && bit_q <= DATA_BIT) ? 1'b0 : frame_q[N-2];
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE || state_d == S_FINISH)
      sout_d = 1'b0;
    // only a frame that ran through its last sclk high updates rdata
    if (state_d == S_FINISH && state_q == S_HIGH && read_q)
      rdata_d = rx_d;

    sclk_d = (state_d == S_HIGH);
    busy_d = (state_d == S_LOW) || (state_d == S_HIGH);
    cs_n_d = ~busy_d;
    done_d = (state_d == S_FINISH) && (state_q != S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      stall_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      sout_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      stall_q <= stall_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      sout_q  <= sout_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign sclk_o       = sclk_q;
  assign cs_n_o       = cs_n_q;
  assign serial_out_o = sout_q;

endmodule

`default_nettype wire

// File: tb/tb_jrb_serial_mem_bridge.sv
// ============================================================================
// tb_jrb_serial_mem_bridge : directed vector bench for jrb_serial_mem_bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jrb_serial_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: ADDR_W=8 DATA_W=8 NUM_CH=2 CLK_DIV=1 TIMEOUT=16 -> N=18
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [0:0] a_ch = '0;
  logic [7:0] a_addr = '0, a_wdata = '0;
  logic       a_busy, a_done, a_err, a_sclk, a_cs_n, a_sout;
  logic [7:0] a_rdata;
  logic       a_sin = 1'b0, a_ready = 1'b1;

  // DUT B: NUM_CH=3 CLK_DIV=2 TIMEOUT=0 -> CH_W=2, N=19
  logic       b_req = 1'b0, b_we = 1'b0;
  logic [1:0] b_ch = '0;
  logic [7:0] b_addr = '0, b_wdata = '0;
  logic       b_busy, b_done, b_err, b_sclk, b_cs_n, b_sout;
  logic [7:0] b_rdata;
  logic       b_sin = 1'b0, b_ready = 1'b1;

  jrb_serial_mem_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_CH(2), .CLK_DIV(1), .TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we), .ch_i(a_ch), .addr_i(a_addr),
    .wdata_i(a_wdata), .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .rdata_o(a_rdata),
    .sclk_o(a_sclk), .cs_n_o(a_cs_n), .serial_out_o(a_sout), .serial_in_i(a_sin),
    .ready_i(a_ready));

  jrb_serial_mem_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_CH(3), .CLK_DIV(2), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we), .ch_i(b_ch), .addr_i(b_addr),
    .wdata_i(b_wdata), .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .rdata_o(b_rdata),
    .sclk_o(b_sclk), .cs_n_o(b_cs_n), .serial_out_o(b_sout), .serial_in_i(b_sin),
    .ready_i(b_ready));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // host model for A: drives serial_in/ready while sclk is low, records bits at sclk rises
  int          a_rises = 0;
  logic [17:0] a_cap = '0;
  logic [7:0]  host_byte = '0;
  int          stall_at = -1;
  int          stall_left = 0;
  int          sout_viol = 0;
  logic        a_sclk_p = 1'b0, a_sout_p = 1'b0, a_cs_n_p = 1'b1;

  always @(negedge clk) begin
    int idx;
    if (a_sclk && !a_sclk_p) begin
      a_rises++;
      a_cap = {a_cap[16:0], a_sout};
    end
    if (a_sclk && (a_sout !== a_sout_p)) sout_viol++;
    if (!a_sclk && !a_sclk_p && !a_cs_n && !a_cs_n_p && (a_sout !== a_sout_p)) sout_viol++;
    a_sclk_p = a_sclk;
    a_sout_p = a_sout;
    a_cs_n_p = a_cs_n;
    if (!a_cs_n && !a_sclk) begin
      idx   = 17 - a_rises;
      a_sin = (idx >= 0 && idx < 8) ? host_byte[idx] : 1'b0;
      if (a_rises == stall_at && stall_left > 0) begin
        a_ready = 1'b0;
        stall_left--;
      end else begin
        a_ready = 1'b1;
      end
    end else begin
      a_ready = 1'b1;
    end
  end

  int          b_rises = 0;
  logic [18:0] b_cap = '0;
  logic        b_sclk_p = 1'b0;

  always @(negedge clk) begin
    if (b_sclk && !b_sclk_p) begin
      b_rises++;
      b_cap = {b_cap[17:0], b_sout};
    end
    b_sclk_p = b_sclk;
  end

  typedef struct {
    string       name;
    logic        we;
    logic        ch;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  host;
    int          stall_at;
    int          stall_len;
    int          exp_lat;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    logic [17:0] exp_frame;
    int          exp_rises;
  } vec_t;

  function automatic vec_t mkv(string n, logic we, logic ch, logic [7:0] addr, logic [7:0] wd,
                               logic [7:0] host, int sat, int slen, int lat, logic e,
                               logic [7:0] rd, logic [17:0] fr, int rises);
    vec_t v;
    v.name = n; v.we = we; v.ch = ch; v.addr = addr; v.wdata = wd; v.host = host;
    v.stall_at = sat; v.stall_len = slen; v.exp_lat = lat; v.exp_err = e;
    v.exp_rdata = rd; v.exp_frame = fr; v.exp_rises = rises;
    return v;
  endfunction

  // latency = rising edges counted from the req-sampling edge through the edge raising done
  task automatic run_a(input vec_t v);
    int cyc;
    bit seen;
    @(negedge clk);
    host_byte  = v.host;
    stall_at   = v.stall_at;
    stall_left = v.stall_len;
    a_rises    = 0;
    a_cap      = '0;
    sout_viol  = 0;
    a_req = 1'b1; a_we = v.we; a_ch = v.ch; a_addr = v.addr; a_wdata = v.wdata;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        a_req   = 1'b0;
        a_addr  = ~v.addr;
        a_wdata = ~v.wdata;
      end
      if (a_done) seen = 1'b1;
    end
    chk({v.name, " latency"}, cyc, v.exp_lat);
    chk({v.name, " err"}, a_err, v.exp_err);
    chk({v.name, " rdata@done"}, a_rdata, v.exp_rdata);
    chk({v.name, " busy@done"}, a_busy, 1'b0);
    chk({v.name, " cs_n@done"}, a_cs_n, 1'b1);
    chk({v.name, " sclk rises"}, a_rises, v.exp_rises);
    if (!v.exp_err) chk({v.name, " frame bits"}, a_cap, v.exp_frame);
    chk({v.name, " sout stability"}, sout_viol, 0);
    @(posedge clk);
    #1;
    chk({v.name, " done pulse"}, a_done, 1'b0);
    chk({v.name, " rdata held"}, a_rdata, v.exp_rdata);
  endtask

  vec_t vecs[7];

  initial begin
    int cyc, first, second, gap;
    bit gap_done, done_seen;

    vecs[0] = mkv("wr_ch1_5A_C3", 1, 1, 8'h5A, 8'hC3, 8'h00, -1,  0, 37, 0, 8'h00, 18'h35AC3, 18);
    vecs[1] = mkv("rd_ch0_10_A5", 0, 0, 8'h10, 8'h77, 8'hA5, -1,  0, 37, 0, 8'hA5, 18'h01000, 18);
    vecs[2] = mkv("wr_stall5",    1, 0, 8'h33, 8'h3C, 8'h00,  3,  5, 42, 0, 8'hA5, 18'h2333C, 18);
    vecs[3] = mkv("rd_timeout_b0", 0, 1, 8'h80, 8'h00, 8'hFF,  0, 1000, 17, 1, 8'hA5, 18'h0, 0);
    vecs[4] = mkv("rd_ch1_FF_3C", 0, 1, 8'hFF, 8'h00, 8'h3C, -1,  0, 37, 0, 8'h3C, 18'h1FF00, 18);
    vecs[5] = mkv("rd_timeout_b10", 0, 0, 8'h20, 8'h00, 8'h99, 10, 16, 37, 1, 8'h3C, 18'h0, 10);
    vecs[6] = mkv("wr_stall15",   1, 1, 8'h01, 8'h80, 8'h00, 17, 15, 52, 0, 8'h3C, 18'h30180, 18);

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", a_busy, 1'b0);
    chk("reset done", a_done, 1'b0);
    chk("reset err", a_err, 1'b0);
    chk("reset rdata", a_rdata, 8'h00);
    chk("reset sclk", a_sclk, 1'b0);
    chk("reset cs_n", a_cs_n, 1'b1);
    chk("reset sout", a_sout, 1'b0);
    chk("reset b cs_n", b_cs_n, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_a(vecs[i]);

    // async reset in the middle of a frame
    @(negedge clk);
    a_rises = 0; stall_at = -1;
    a_req = 1'b1; a_we = 1'b1; a_ch = 1'b0; a_addr = 8'h12; a_wdata = 8'h34;
    @(posedge clk);
    #1 a_req = 1'b0;
    cyc = 0;
    while (a_rises < 9 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("rst reached bit9", a_rises, 9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst cs_n", a_cs_n, 1'b1);
    chk("rst sclk", a_sclk, 1'b0);
    chk("rst busy", a_busy, 1'b0);
    chk("rst rdata", a_rdata, 8'h00);
    done_seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 if (a_done) done_seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (a_done) done_seen = 1'b1;
    end
    chk("rst no done", done_seen, 1'b0);
    run_a(mkv("wr_after_rst", 1, 1, 8'h01, 8'hFF, 8'h00, -1, 0, 37, 0, 8'h00, 18'h301FF, 18));

    // req held high across two frames
    @(negedge clk);
    a_rises = 0; stall_at = -1;
    a_req = 1'b1; a_we = 1'b1; a_ch = 1'b1; a_addr = 8'hAA; a_wdata = 8'h55;
    cyc = 0; first = 0; second = 0; gap = 0; gap_done = 1'b0;
    while (second == 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (a_done) begin
        if (first == 0) first = cyc;
        else second = cyc;
      end
      if (first != 0 && !gap_done) begin
        if (a_cs_n) gap++;
        else gap_done = 1'b1;
      end
    end
    a_req = 1'b0;
    chk("held req first done", first, 37);
    chk("held req second done", second, 75);
    chk("held req cs_n gap", gap, 2);
    chk("held req rises", a_rises, 36);
    repeat (3) @(posedge clk);
    #1 chk("held req idle after", a_busy, 1'b0);

    // NUM_CH=3: channel 3 is rejected without touching the link
    @(negedge clk);
    b_rises = 0;
    b_req = 1'b1; b_we = 1'b0; b_ch = 2'd3; b_addr = 8'h44;
    @(posedge clk);
    #1;
    b_req = 1'b0;
    chk("badch done", b_done, 1'b1);
    chk("badch err", b_err, 1'b1);
    chk("badch cs_n", b_cs_n, 1'b1);
    chk("badch busy", b_busy, 1'b0);
    @(posedge clk);
    #1;
    chk("badch done pulse", b_done, 1'b0);
    chk("badch err pulse", b_err, 1'b0);
    chk("badch no sclk", b_rises, 0);

    // CLK_DIV=2 write on channel 2: 1 + 2*19*2 = 77
    @(negedge clk);
    b_rises = 0; b_cap = '0;
    b_req = 1'b1; b_we = 1'b1; b_ch = 2'd2; b_addr = 8'h5A; b_wdata = 8'hC3;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      b_req = 1'b0;
      if (b_done) done_seen = 1'b1;
    end
    chk("div2 latency", cyc, 77);
    chk("div2 err", b_err, 1'b0);
    chk("div2 frame bits", b_cap, 19'h65AC3);
    chk("div2 rises", b_rises, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
